// File: rtl/bus_reg_bank_if.sv
// Local-bus interface between the bus bridge (master) and register-bank slaves.
//   baddr    : bus address
//   bwrdata  : write data
//   brddata  : read data returned by the slave (zero when the slave is not addressed)
//   bwr      : 1 = write, 0 = read; qualified by bstrobe
//   bstrobe  : one-cycle transaction strobe
interface bus_if #(
    parameter int unsigned DW = 16
);
    logic [15:0]   baddr;
    logic [DW-1:0] bwrdata;
    logic [DW-1:0] brddata;
    logic          bwr;
    logic          bstrobe;

    modport master (output baddr, output bwrdata, output bwr, output bstrobe, input brddata);
    modport slave  (input baddr, input bwrdata, input bwr, input bstrobe, output brddata);
endinterface

// File: rtl/bus_reg_bank.sv
// Parametrised local-bus slave: R/W control registers with write pulses,
// read-only status registers, saturating clear-on-write event counters and an ID word,
// all in one address window. Read data is zero outside the window so several
// instances on one bus can be OR-combined.
//   clk, reset : clock, synchronous active-high reset
//   bus        : local-bus slave port (baddr, bwrdata, brddata, bwr, bstrobe)
//   rw_out     : R/W register contents, reg i at [16*i+15:16*i]
//   wpulse     : one-cycle pulse per R/W register on write
//   ro_in      : status inputs, reg j at [16*j+15:16*j]
//   ev_in      : event inputs, one per counter
//   cnt_out    : live counter values
module bus_reg_bank #(
    parameter logic [15:0] ABASE    = 16'h0000,
    parameter int unsigned NRW      = 8,
    parameter int unsigned NRO      = 8,
    parameter int unsigned NCNT     = 4,
    parameter int unsigned DW       = 16,
    parameter logic [15:0] RW_RESET = 16'h0000,
    parameter bit          RD_PIPE  = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    bus_if.slave                                  bus,
    output logic [NRW*DW-1:0]                     rw_out,
    output logic [NRW-1:0]                        wpulse,
    input  logic [((NRO > 0) ? NRO : 1)*DW-1:0]   ro_in,
    input  logic [((NCNT > 0) ? NCNT : 1)-1:0]    ev_in,
    output logic [((NCNT > 0) ? NCNT : 1)*DW-1:0] cnt_out
);

    localparam int unsigned NRO_A    = (NRO > 0) ? NRO : 1;
    localparam int unsigned NCNT_A   = (NCNT > 0) ? NCNT : 1;
    localparam int unsigned CNT_BASE = NRW + NRO;
    localparam int unsigned ID_OFF   = NRW + NRO + NCNT;
    localparam int unsigned WSIZE    = ID_OFF + 1;
    localparam logic [DW-1:0] ID_VAL = DW'({8'(NRW), 4'(NRO), 4'(NCNT)});

    logic [15:0]   offset;
    logic          hit;
    logic          wr;
    logic [DW-1:0] rw_q   [NRW];
    logic [DW-1:0] ro_q   [NRO_A];
    logic [DW-1:0] cnt_q  [NCNT_A];
    logic [DW-1:0] rd_words [WSIZE];
    logic [DW-1:0] rd_c;

    // ABASE is aligned, so a simple subtract-and-compare is the window match
    assign offset = bus.baddr - ABASE;
    assign hit    = (offset < 16'(WSIZE));
    assign wr     = bus.bstrobe & bus.bwr & hit;

    // R/W registers and their write pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NRW; i++) rw_q[i] <= DW'(RW_RESET);
            wpulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NRW; i++) begin
                wpulse[i] <= wr && (offset == 16'(i));
                if (wr && (offset == 16'(i))) rw_q[i] <= bus.bwrdata;
            end
        end
    end

    // Status capture: one register stage on every RO input
    generate
        if (NRO > 0) begin : g_ro
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned j = 0; j < NRO; j++) ro_q[j] <= '0;
                end else begin
                    for (int unsigned j = 0; j < NRO; j++) ro_q[j] <= ro_in[j*DW +: DW];
                end
            end
        end else begin : g_no_ro
            assign ro_q[0] = '0;
        end
    endgenerate

    // Event counters: a write clears and takes priority over a same-cycle event
    generate
        if (NCNT > 0) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned k = 0; k < NCNT; k++) cnt_q[k] <= '0;
                end else begin
                    for (int unsigned k = 0; k < NCNT; k++) begin
                        if (wr && (offset == 16'(CNT_BASE + k))) begin
                            cnt_q[k] <= '0;
                        end else if (ev_in[k] && (cnt_q[k] != '1)) begin
                            cnt_q[k] <= cnt_q[k] + DW'(1);
                        end
                    end
                end
            end
        end else begin : g_no_cnt
            assign cnt_q[0] = '0;
        end
    endgenerate

    // Flatten all readable words into address order
    always_comb begin
        for (int unsigned w = 0; w < WSIZE; w++) rd_words[w] = '0;
        for (int unsigned i = 0; i < NRW; i++)  rd_words[i] = rw_q[i];
        for (int unsigned j = 0; j < NRO; j++)  rd_words[NRW + j] = ro_q[j];
        for (int unsigned k = 0; k < NCNT; k++) rd_words[CNT_BASE + k] = cnt_q[k];
        rd_words[ID_OFF] = ID_VAL;
    end

    // Read mux; any offset outside the window leaves the zero default
    always_comb begin
        rd_c = '0;
        for (int unsigned w = 0; w < WSIZE; w++) begin
            if (offset == 16'(w)) rd_c = rd_words[w];
        end
    end

    // Output packing
    always_comb begin
        rw_out  = '0;
        cnt_out = '0;
        for (int unsigned i = 0; i < NRW; i++)  rw_out[i*DW +: DW]  = rw_q[i];
        for (int unsigned k = 0; k < NCNT; k++) cnt_out[k*DW +: DW] = cnt_q[k];
    end

    generate
        if (RD_PIPE) begin : g_rd_pipe
            logic [DW-1:0] brddata_q;
            always_ff @(posedge clk) begin
                if (reset) brddata_q <= '0;
                else       brddata_q <= rd_c;
            end
            assign bus.brddata = brddata_q;
        end else begin : g_rd_comb
            assign bus.brddata = rd_c;
        end
    endgenerate

endmodule
